// File: rtl/ram_burst_pkg.sv
// Shared types and defaults for the burst RAM controller and its RAM model.
package ram_burst_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W  = 4;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_READ_OUT  = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/ram_sp.sv
// Synchronous single-port RAM: write on cs&wr, registered read on cs&rd
// (data appears the cycle after the read strobe).
module ram_sp
  import ram_burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_cs,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  // Storage array and one-cycle read register
  always_ff @(posedge i_clk) begin
    if (i_cs && i_wr) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_cs && i_rd) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller: moves 1..2^LEN_W words between valid/ready streams and a
// synchronous single-port RAM, one command per burst.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_cs,
  output logic              o_rd,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e            r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_busy;
  logic              r_done;
  logic              r_wr_ready;
  logic              r_rd_valid;
  logic              r_rd_req;

  logic              w_wr_beat;
  logic              w_last;
  logic [DATA_W-1:0] w_ram_wdata;

  // Write strobes follow wr_valid in the same cycle so a beat costs one clock.
  assign w_wr_beat = r_wr_ready & i_wr_valid;
  assign w_last    = (r_cnt == r_len);

  // Burst sequencer; status outputs are registered alongside the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cur_addr <= {ADDR_W{1'b0}};
      r_len      <= {LEN_W{1'b0}};
      r_cnt      <= {LEN_W{1'b0}};
      r_rd_data  <= {DATA_W{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_req   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_cur_addr <= i_addr;
            r_len      <= i_len;
            r_cnt      <= {LEN_W{1'b0}};
            r_busy     <= 1'b1;
            case (i_rw)
              RW_WRITE: begin
                r_state    <= ST_WRITE;
                r_wr_ready <= 1'b1;
              end
              RW_READ: begin
                r_state  <= ST_READ_REQ;
                r_rd_req <= 1'b1;
              end
              default: begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            endcase
          end
        end
        ST_WRITE: begin
          if (i_wr_valid) begin
            if (w_last) begin
              r_state    <= ST_DONE;
              r_wr_ready <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_cur_addr <= r_cur_addr + ADDR_ONE;
              r_cnt      <= r_cnt + CNT_ONE;
            end
          end
        end
        ST_READ_REQ: begin
          r_state  <= ST_READ_WAIT;
          r_rd_req <= 1'b0;
        end
        ST_READ_WAIT: begin
          r_rd_data  <= i_ram_rdata;
          r_state    <= ST_READ_OUT;
          r_rd_valid <= 1'b1;
        end
        ST_READ_OUT: begin
          if (i_rd_ready) begin
            r_rd_valid <= 1'b0;
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cur_addr <= r_cur_addr + ADDR_ONE;
              r_cnt      <= r_cnt + CNT_ONE;
              r_state    <= ST_READ_REQ;
              r_rd_req   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_wr_ready <= 1'b0;
          r_rd_valid <= 1'b0;
          r_rd_req   <= 1'b0;
        end
      endcase
    end
  end

  // Write data is only driven onto the RAM bus during an accepted beat
  always_comb begin
    w_ram_wdata = {DATA_W{1'b0}};
    if (w_wr_beat) begin
      w_ram_wdata = i_wr_data;
    end else begin
      w_ram_wdata = {DATA_W{1'b0}};
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_wr_ready  = r_wr_ready;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_cs        = w_wr_beat | r_rd_req;
  assign o_wr        = w_wr_beat;
  assign o_rd        = r_rd_req;
  assign o_ram_addr  = r_cur_addr;
  assign o_ram_wdata = w_ram_wdata;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl with a ram_sp behind it; a flat memory array and
// address arithmetic modulo 256 provide the expected values.
module tb_ram_burst_ctrl;
  import ram_burst_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          rw;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          cs;
  logic          rd;
  logic          wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  int mon_cyc = 0;
  int mon_busy = 0;
  int mon_done = 0;
  int mon_wr = 0;
  int mon_rd = 0;
  int mon_bad = 0;
  logic [7:0] log_wa [4096];
  logic [7:0] log_wd [4096];
  int         log_wc [4096];
  logic [7:0] log_ra [4096];

  logic [7:0] ref_mem [256];
  logic [7:0] wbuf [16];
  logic [7:0] rbuf [16];

  always #5 clk = ~clk;

  ram_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rw(rw), .i_addr(addr),
    .i_len(len), .o_busy(busy), .o_done(done), .i_wr_data(wr_data),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .o_rd_data(rd_data),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_cs(cs), .o_rd(rd),
    .o_wr(wr), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  ram_sp #(.DATA_W(DW), .ADDR_W(AW)) u_ram (
    .i_clk(clk), .i_cs(cs), .i_rd(rd), .i_wr(wr), .i_addr(ram_addr),
    .i_wdata(ram_wdata), .o_rdata(ram_rdata)
  );

  // Bus monitor sampling on the falling edge
  always @(negedge clk) begin
    mon_cyc <= mon_cyc + 1;
    if (busy) mon_busy <= mon_busy + 1;
    if (done) mon_done <= mon_done + 1;
    if (wr) begin
      log_wa[mon_wr % 4096] <= ram_addr;
      log_wd[mon_wr % 4096] <= ram_wdata;
      log_wc[mon_wr % 4096] <= mon_cyc;
      mon_wr <= mon_wr + 1;
    end
    if (rd) begin
      log_ra[mon_rd % 4096] <= ram_addr;
      mon_rd <= mon_rd + 1;
    end
    if ((wr && rd) || ((wr || rd) && !cs) || (cs && !wr && !rd)) mon_bad <= mon_bad + 1;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, expected 0", busy, n);
    end
  endtask

  // mode 0: continuous valid, 1: valid low for gl cycles from cycle gs, 2: random valid
  task automatic do_write(input logic [7:0] a, input int l, input int mode,
                          input int gs, input int gl, input int sp);
    int cyc, beat;
    logic vld, acc;
    @(posedge clk); #1;
    start = 1'b1; rw = RW_WRITE; addr = a; len = 4'(l); wr_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; beat = 0;
    while (beat <= l && cyc < 400) begin
      if (mode == 2) vld = 1'($urandom_range(0, 1));
      else if (mode == 1 && cyc >= gs && cyc < gs + gl) vld = 1'b0;
      else vld = 1'b1;
      wr_valid = vld;
      wr_data = vld ? wbuf[beat] : 8'($urandom);
      if (cyc == sp) begin
        start = 1'b1; rw = RW_READ; addr = 8'h00; len = 4'hF;
      end else begin
        start = 1'b0;
      end
      acc = vld && wr_ready;
      @(posedge clk); #1;
      if (acc) beat++;
      cyc++;
    end
    start = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i <= l; i++) ref_mem[8'(int'(a) + i)] = wbuf[i];
    wait_idle();
  endtask

  task automatic do_read(input logic [7:0] a, input int l, input bit rnd);
    int cyc, beat;
    @(posedge clk); #1;
    start = 1'b1; rw = RW_READ; addr = a; len = 4'(l); rd_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; beat = 0;
    while (beat <= l && cyc < 800) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid && rd_ready) begin
        rbuf[beat] = rd_data;
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = 8'h00; len = 4'h0;
    wr_data = 8'h5A; wr_valid = 1'b1; rd_ready = 1'b1;
    #1;
    checks++;
    if ({busy, done, wr_ready, rd_valid, cs, rd, wr} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: {busy,done,wr_ready,rd_valid,cs,rd,wr}=%b expected 0000000",
               {busy, done, wr_ready, rd_valid, cs, rd, wr});
    end
    checks++;
    if (rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    end
    checks++;
    if (ram_addr !== 8'h00 || ram_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_ram_bus: addr=%h wdata=%h expected 00/00", ram_addr, ram_wdata);
    end
    repeat (3) @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || mon_wr !== 0) begin
      errors++; $display("FAIL reset_idle: busy=%0b writes=%0d expected 0/0", busy, mon_wr);
    end
  endtask

  task automatic test_single();
    int sw, sd, sr;
    sw = mon_wr; sd = mon_done; sr = mon_rd;
    wbuf[0] = 8'hAA;
    do_write(8'h05, 0, 0, 0, 0, -1);
    checks++;
    if (mon_wr - sw !== 1 || mon_done - sd !== 1 || mon_rd - sr !== 0) begin
      errors++;
      $display("FAIL single_wr_counts: wr=%0d done=%0d rd=%0d expected 1/1/0",
               mon_wr - sw, mon_done - sd, mon_rd - sr);
    end
    checks++;
    if (log_wa[sw % 4096] !== 8'h05 || log_wd[sw % 4096] !== 8'hAA) begin
      errors++;
      $display("FAIL single_wr_bus: addr=%h data=%h expected 05/AA", log_wa[sw % 4096], log_wd[sw % 4096]);
    end
    sw = mon_wr; sd = mon_done; sr = mon_rd;
    do_read(8'h05, 0, 1'b0);
    checks++;
    if (mon_rd - sr !== 1 || mon_done - sd !== 1 || mon_wr - sw !== 0) begin
      errors++;
      $display("FAIL single_rd_counts: rd=%0d done=%0d wr=%0d expected 1/1/0",
               mon_rd - sr, mon_done - sd, mon_wr - sw);
    end
    checks++;
    if (rbuf[0] !== 8'hAA || log_ra[sr % 4096] !== 8'h05) begin
      errors++;
      $display("FAIL single_rd_data: data=%h addr=%h expected AA/05", rbuf[0], log_ra[sr % 4096]);
    end
  endtask

  task automatic test_burst();
    int sw, sb;
    for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hA0 + i);
    sw = mon_wr; sb = mon_busy;
    do_write(8'h10, 3, 0, 0, 0, -1);
    checks++;
    if (mon_wr - sw !== 4 || mon_busy - sb !== 5) begin
      errors++;
      $display("FAIL burst_wr_cycles: writes=%0d busy=%0d expected 4/5", mon_wr - sw, mon_busy - sb);
    end
    checks++;
    if (log_wc[(sw + 3) % 4096] - log_wc[sw % 4096] !== 3) begin
      errors++;
      $display("FAIL burst_wr_consecutive: span=%0d expected 3",
               log_wc[(sw + 3) % 4096] - log_wc[sw % 4096]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_wa[(sw + i) % 4096] !== 8'(8'h10 + i) || log_wd[(sw + i) % 4096] !== 8'(8'hA0 + i)) begin
        errors++;
        $display("FAIL burst_wr_beat%0d: addr=%h data=%h expected %h/%h", i,
                 log_wa[(sw + i) % 4096], log_wd[(sw + i) % 4096], 8'(8'h10 + i), 8'(8'hA0 + i));
      end
    end
    sb = mon_busy;
    do_read(8'h10, 3, 1'b0);
    checks++;
    if (mon_busy - sb !== 13) begin
      errors++; $display("FAIL burst_rd_busy: got %0d expected 13", mon_busy - sb);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== 8'(8'hA0 + i)) begin
        errors++; $display("FAIL burst_rd_beat%0d: got %h expected %h", i, rbuf[i], 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_wrap();
    int sw, sr;
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    sw = mon_wr;
    do_write(8'hFE, 3, 0, 0, 0, -1);
    sr = mon_rd;
    do_read(8'hFE, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_wa[(sw + i) % 4096] !== 8'(254 + i) || log_ra[(sr + i) % 4096] !== 8'(254 + i)) begin
        errors++;
        $display("FAIL wrap_addr%0d: wr_addr=%h rd_addr=%h expected %h", i,
                 log_wa[(sw + i) % 4096], log_ra[(sr + i) % 4096], 8'(254 + i));
      end
      checks++;
      if (rbuf[i] !== ref_mem[8'(254 + i)]) begin
        errors++; $display("FAIL wrap_data%0d: got %h expected %h", i, rbuf[i], ref_mem[8'(254 + i)]);
      end
    end
  endtask

  task automatic test_backpressure();
    int sw, sb, sr, r0, n;
    logic [7:0] d0;
    for (int i = 0; i < 6; i++) wbuf[i] = 8'($urandom);
    sw = mon_wr; sb = mon_busy;
    do_write(8'h40, 5, 1, 2, 2, -1);
    checks++;
    if (mon_wr - sw !== 6 || mon_busy - sb !== 9) begin
      errors++;
      $display("FAIL bp_wr_counts: writes=%0d busy=%0d expected 6/9", mon_wr - sw, mon_busy - sb);
    end
    checks++;
    if (log_wc[(sw + 1) % 4096] - log_wc[sw % 4096] !== 1 ||
        log_wc[(sw + 2) % 4096] - log_wc[(sw + 1) % 4096] !== 3) begin
      errors++;
      $display("FAIL bp_wr_gap: spacing=%0d,%0d expected 1,3",
               log_wc[(sw + 1) % 4096] - log_wc[sw % 4096],
               log_wc[(sw + 2) % 4096] - log_wc[(sw + 1) % 4096]);
    end
    checks++;
    if (log_wd[(sw + 2) % 4096] !== wbuf[2] || log_wa[(sw + 2) % 4096] !== 8'h42) begin
      errors++;
      $display("FAIL bp_wr_resume: addr=%h data=%h expected 42/%h",
               log_wa[(sw + 2) % 4096], log_wd[(sw + 2) % 4096], wbuf[2]);
    end
    sr = mon_rd;
    @(posedge clk); #1;
    start = 1'b1; rw = RW_READ; addr = 8'h40; len = 4'd1; rd_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!rd_valid && n < 20) begin @(posedge clk); #1; n++; end
    d0 = rd_data;
    checks++;
    if (rd_valid !== 1'b1 || d0 !== ref_mem[8'h40]) begin
      errors++;
      $display("FAIL bp_rd_first: valid=%0b data=%h expected 1/%h", rd_valid, d0, ref_mem[8'h40]);
    end
    r0 = mon_rd;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== d0) begin
        errors++;
        $display("FAIL bp_rd_hold: valid=%0b data=%h expected 1/%h", rd_valid, rd_data, d0);
      end
    end
    checks++;
    if (mon_rd !== r0) begin
      errors++; $display("FAIL bp_rd_extra: rd strobes during stall=%0d expected 0", mon_rd - r0);
    end
    rd_ready = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!rd_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== ref_mem[8'h41]) begin
      errors++;
      $display("FAIL bp_rd_second: valid=%0b data=%h expected 1/%h", rd_valid, rd_data, ref_mem[8'h41]);
    end
    wait_idle();
    checks++;
    if (mon_rd - sr !== 2) begin
      errors++; $display("FAIL bp_rd_count: got %0d expected 2", mon_rd - sr);
    end
  endtask

  task automatic test_start_while_busy();
    int sw, sd, sr, sb;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
    sw = mon_wr; sd = mon_done; sr = mon_rd;
    do_write(8'h80, 7, 0, 0, 0, 3);
    checks++;
    if (mon_wr - sw !== 8 || mon_done - sd !== 1 || mon_rd - sr !== 0) begin
      errors++;
      $display("FAIL busy_start_counts: wr=%0d done=%0d rd=%0d expected 8/1/0",
               mon_wr - sw, mon_done - sd, mon_rd - sr);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (log_wa[(sw + i) % 4096] !== 8'(8'h80 + i)) begin
        errors++;
        $display("FAIL busy_start_addr%0d: got %h expected %h", i, log_wa[(sw + i) % 4096], 8'(8'h80 + i));
      end
    end
    sb = mon_busy;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (mon_busy !== sb) begin
      errors++; $display("FAIL busy_start_queued: busy cycles after burst=%0d expected 0", mon_busy - sb);
    end
  endtask

  task automatic test_reset_mid_burst();
    int sr, sd, rc, n, k;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
    do_write(8'h20, 7, 0, 0, 0, -1);
    sr = mon_rd; sd = mon_done;
    @(posedge clk); #1;
    start = 1'b1; rw = RW_READ; addr = 8'h20; len = 4'd7; rd_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; k = 0;
    while (k < 3 && n < 100) begin
      if (rd) k++;
      if (k < 3) begin @(posedge clk); #1; n++; end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (k !== 3 || {busy, done, wr_ready, rd_valid, cs, rd, wr} !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: beats=%0d {busy,done,wr_ready,rd_valid,cs,rd,wr}=%b expected 3/0000000",
               k, {busy, done, wr_ready, rd_valid, cs, rd, wr});
    end
    checks++;
    if (rd_data !== 8'h00 || ram_addr !== 8'h00 || ram_wdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_data: rd_data=%h ram_addr=%h ram_wdata=%h expected 00/00/00",
               rd_data, ram_addr, ram_wdata);
    end
    rc = mon_rd;
    checks++;
    if (rc - sr !== 2) begin
      errors++; $display("FAIL rst_mid_prior: rd strobes before reset=%0d expected 2", rc - sr);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mon_rd !== rc || mon_done !== sd || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: new rd=%0d done=%0d busy=%0b expected 0/0/0",
               mon_rd - rc, mon_done - sd, busy);
    end
    sd = mon_done;
    do_read(8'h20, 0, 1'b0);
    checks++;
    if (rbuf[0] !== ref_mem[8'h20] || mon_done - sd !== 1) begin
      errors++;
      $display("FAIL rst_mid_recover: data=%h done=%0d expected %h/1", rbuf[0], mon_done - sd, ref_mem[8'h20]);
    end
  endtask

  task automatic test_random();
    int sw, sr, l;
    logic [7:0] a;
    for (int it = 0; it < 6; it++) begin
      a = 8'($urandom);
      l = $urandom_range(0, 15);
      for (int i = 0; i <= l; i++) wbuf[i] = 8'($urandom);
      sw = mon_wr;
      do_write(a, l, 2, 0, 0, -1);
      checks++;
      if (mon_wr - sw !== l + 1) begin
        errors++; $display("FAIL rand_wr_count: got %0d expected %0d", mon_wr - sw, l + 1);
      end
      for (int i = 0; i <= l; i++) begin
        checks++;
        if (log_wa[(sw + i) % 4096] !== 8'(int'(a) + i) || log_wd[(sw + i) % 4096] !== wbuf[i]) begin
          errors++;
          $display("FAIL rand_wr_beat: addr=%h data=%h expected %h/%h",
                   log_wa[(sw + i) % 4096], log_wd[(sw + i) % 4096], 8'(int'(a) + i), wbuf[i]);
        end
      end
      sr = mon_rd;
      do_read(a, l, 1'b1);
      checks++;
      if (mon_rd - sr !== l + 1) begin
        errors++; $display("FAIL rand_rd_count: got %0d expected %0d", mon_rd - sr, l + 1);
      end
      for (int i = 0; i <= l; i++) begin
        checks++;
        if (rbuf[i] !== ref_mem[8'(int'(a) + i)] || log_ra[(sr + i) % 4096] !== 8'(int'(a) + i)) begin
          errors++;
          $display("FAIL rand_rd_beat: data=%h addr=%h expected %h/%h", rbuf[i],
                   log_ra[(sr + i) % 4096], ref_mem[8'(int'(a) + i)], 8'(int'(a) + i));
        end
      end
    end
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (mon_bad !== 0) begin
      errors++; $display("FAIL strobe_rules: illegal strobe combinations=%0d expected 0", mon_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_burst();
    test_random();
    test_strobe_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
